// File: rtl/traffic_light_supervisor.sv
// traffic_light_supervisor: top-level supervisor that owns the normal-mode sub-state machine and drives the road lamps.
//   Inserts yellow-then-all-red clearance whenever control is taken away from normal mode.
//   Handles maintenance flash and emergency preemption (emergency > maintenance > normal).
//
//   Ports:
//     clk                              system clock
//     reset_n                          asynchronous active-low reset
//     maintenanceReq                   maintenance/flash mode request
//     emergencyReq                     emergency vehicle preemption request
//     emergencyRoad                    road given green in emergency (0 = primary, 1 = secondary)
//     primaryRoadLight_RYB_normMdSM    primary lights from the sub-state machine
//     secondaryRoadLight_RYB_normMdSM  secondary lights from the sub-state machine
//     normalModeSsmIdle                holds the sub-state machine idle
//     primaryRoadLight_RYB             primary lamp drive {red, yellow, green}
//     secondaryRoadLight_RYB           secondary lamp drive {red, yellow, green}
//     supervisorMode                   current state encoding
//
//   Build option TL_SUPERVISOR_INPUT_SYNC_EN:
//     the three request inputs pass through 2-flop synchronizers.
module traffic_light_supervisor #(
   parameter int TIMER_BITS     = 24,
   parameter int STARTUP_CNT    = 20,
   parameter int YELLOW_CNT     = 30,
   parameter int RED_CNT        = 10,
   parameter int FLASH_HALF_CNT = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       maintenanceReq,
   input  logic       emergencyReq,
   input  logic       emergencyRoad,
   input  logic [2:0] primaryRoadLight_RYB_normMdSM,
   input  logic [2:0] secondaryRoadLight_RYB_normMdSM,
   output logic       normalModeSsmIdle,
   output logic [2:0] primaryRoadLight_RYB,
   output logic [2:0] secondaryRoadLight_RYB,
   output logic [2:0] supervisorMode
);
   typedef enum logic [2:0] {
      STARTUP      = 3'd0,
      NORMAL       = 3'd1,
      CLEAR_YELLOW = 3'd2,
      CLEAR_RED    = 3'd3,
      FLASH        = 3'd4,
      EMERGENCY    = 3'd5
   } state_t;
   localparam logic [2:0] OFF = 3'b000, RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001;
   state_t                state, stateNext;
   logic [TIMER_BITS-1:0] timer, timerNext;
   logic [1:0]            flags, flagsNext;
   logic                  flashOn, flashOnNext, emRoad, emRoadNext;
   logic [2:0]            priNext, secNext;
   logic                  idleNext, timerDone;
   logic                  emReq, mtReq, emRoadIn;
`ifdef TL_SUPERVISOR_INPUT_SYNC_EN
   logic [2:0] syncA, syncB;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= {emergencyRoad, emergencyReq, maintenanceReq};
         syncB <= syncA;
      end
   assign {emRoadIn, emReq, mtReq} = syncB;
`else
   assign {emRoadIn, emReq, mtReq} = {emergencyRoad, emergencyReq, maintenanceReq};
`endif
   assign timerDone      = timer == '0;
   assign supervisorMode = state;
   always_comb begin
      stateNext   = state;
      timerNext   = timerDone ? '0 : timer - 1'b1;
      flagsNext   = flags;
      flashOnNext = flashOn;
      emRoadNext  = emRoad;
      case (state)
         STARTUP:      if (timerDone) stateNext = emReq ? EMERGENCY : mtReq ? FLASH : NORMAL;
         NORMAL:
            if (emReq || mtReq) begin
               // flag every road currently showing anything but red so it gets a yellow clearance
               flagsNext = {secondaryRoadLight_RYB != RED, primaryRoadLight_RYB != RED};
               stateNext = |flagsNext ? CLEAR_YELLOW : CLEAR_RED;
            end
         CLEAR_YELLOW: if (timerDone) stateNext = CLEAR_RED;
         CLEAR_RED:    if (timerDone) stateNext = emReq ? EMERGENCY : mtReq ? FLASH : NORMAL;
         FLASH:
            if (emReq || !mtReq) stateNext = CLEAR_RED;
            else if (timerDone) begin
               flashOnNext = !flashOn;
               timerNext   = TIMER_BITS'(FLASH_HALF_CNT);
            end
         EMERGENCY:
            if (!emReq) begin
               flagsNext = emRoad ? 2'b10 : 2'b01;
               stateNext = CLEAR_YELLOW;
            end
         default:      stateNext = CLEAR_RED;
      endcase
      if (stateNext != state) begin
         timerNext   = stateNext == CLEAR_YELLOW ? TIMER_BITS'(YELLOW_CNT) :
                       stateNext == CLEAR_RED    ? TIMER_BITS'(RED_CNT) :
                       stateNext == FLASH        ? TIMER_BITS'(FLASH_HALF_CNT) : '0;
         flashOnNext = 1'b1;
         if (stateNext == EMERGENCY) emRoadNext = emRoadIn;
      end
      // lamp registers are loaded from the next-state view so they stay aligned with state
      priNext  = RED;
      secNext  = RED;
      idleNext = 1'b1;
      case (stateNext)
         NORMAL: begin
            priNext  = primaryRoadLight_RYB_normMdSM;
            secNext  = secondaryRoadLight_RYB_normMdSM;
            idleNext = 1'b0;
         end
         CLEAR_YELLOW: begin
            priNext = flagsNext[0] ? YELLOW : RED;
            secNext = flagsNext[1] ? YELLOW : RED;
         end
         FLASH: begin
            priNext = flashOnNext ? YELLOW : OFF;
            secNext = flashOnNext ? RED : OFF;
         end
         EMERGENCY: begin
            priNext = emRoadNext ? RED : GREEN;
            secNext = emRoadNext ? GREEN : RED;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state                  <= STARTUP;
         timer                  <= TIMER_BITS'(STARTUP_CNT);
         flags                  <= '0;
         flashOn                <= 1'b1;
         emRoad                 <= 1'b0;
         primaryRoadLight_RYB   <= RED;
         secondaryRoadLight_RYB <= RED;
         normalModeSsmIdle      <= 1'b1;
      end else begin
         state                  <= stateNext;
         timer                  <= timerNext;
         flags                  <= flagsNext;
         flashOn                <= flashOnNext;
         emRoad                 <= emRoadNext;
         primaryRoadLight_RYB   <= priNext;
         secondaryRoadLight_RYB <= secNext;
         normalModeSsmIdle      <= idleNext;
      end
endmodule
